cilantro_dmem_resp: RTL and testbench

Data-memory responder for the cilantro RV core: the slave end of the core's load/store path. Accepts one word-aligned load or store request at a time over a valid/ready handshake, performs it against an internal 4 KB byte-lane RAM after a parameterised access latency, and returns read data plus an error flag over a second valid/ready handshake. Sits between the core's memory stage and the data RAM; the core stalls on `req_ready`/`rsp_valid`.

---
 rtl/cilantro_pkg.sv | 19 +
 rtl/cilantro_dmem_array.sv | 35 +++
 rtl/cilantro_dmem_resp.sv | 131 +++++++++++++
 tb/tb_cilantro_dmem_resp.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/cilantro_pkg.sv
// Shared constants for the cilantro data-memory path: responder state encoding,
// load/store opcodes and word/byte-lane geometry.
package cilantro_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } dmem_state_t;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  localparam int DATA_W     = 32;
  localparam int BYTE_W     = 8;
  localparam int BE_W       = DATA_W / BYTE_W;
  localparam int WORD_BYTES = BE_W;

endpackage

// File: rtl/cilantro_dmem_array.sv
// Single-port word RAM with per-byte write enables and a registered read port.
// The read register only updates on a read access, so it holds a response steady.
module cilantro_dmem_array
  import cilantro_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic              i_clk,
  input  logic              i_en,
  input  logic              i_we,
  input  logic [BE_W-1:0]   i_be,
  input  logic [AW-1:0]     i_idx,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [DEPTH_WORDS];
  logic [DATA_W-1:0] r_rdata;

  always_ff @(posedge i_clk) begin
    if (i_en) begin
      if (i_we) begin
        for (int b = 0; b < BE_W; b++) begin
          if (i_be[b]) r_mem[i_idx][b*BYTE_W +: BYTE_W] <= i_wdata[b*BYTE_W +: BYTE_W];
        end
      end else begin
        r_rdata <= r_mem[i_idx];
      end
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/cilantro_dmem_resp.sv
// Data-memory responder: one load/store at a time, fixed access latency, response
// held until the requester takes it. Stores commit on the acceptance edge.
module cilantro_dmem_resp
  import cilantro_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic              i_req_we,
  input  logic [31:0]       i_req_addr,
  input  logic [DATA_W-1:0] i_req_wdata,
  input  logic [BE_W-1:0]   i_req_be,
  output logic              o_rsp_valid,
  input  logic              i_rsp_ready,
  output logic [DATA_W-1:0] o_rsp_rdata,
  output logic              o_rsp_err
);

  localparam int AW = $clog2(DEPTH_WORDS);

  function automatic logic addr_err(input logic [31:0] addr);
    return (addr[1:0] != 2'b00) || (addr[31:AW+2] != '0);
  endfunction

  dmem_state_t       r_state, w_state_nxt;
  logic              r_req_ready;
  logic [3:0]        r_cnt, w_cnt_nxt;
  logic              r_we, r_err, r_rd_sel;
  logic [AW-1:0]     r_idx;
  logic              w_accept, w_err_in, w_rd_load;
  logic              w_ram_en, w_ram_we;
  logic [AW-1:0]     w_ram_idx;
  logic [DATA_W-1:0] w_ram_q;

  assign w_accept = r_req_ready && i_req_valid && !i_rst;
  assign w_err_in = addr_err(i_req_addr);

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_ram_en    = 1'b0;
    w_ram_we    = 1'b0;
    w_ram_idx   = r_idx;
    w_rd_load   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_ram_idx = i_req_addr[AW+1:2];
          if (LATENCY > 1) begin
            w_state_nxt = ST_WAIT;
            w_cnt_nxt   = 4'(LATENCY - 1);
          end else begin
            w_state_nxt = ST_RESP;
          end
          // Errored requests never reach the RAM; a latency-1 load reads right away.
          if (!w_err_in) begin
            if (i_req_we) begin
              w_ram_en = 1'b1;
              w_ram_we = 1'b1;
            end else if (LATENCY == 1) begin
              w_ram_en  = 1'b1;
              w_rd_load = 1'b1;
            end
          end
        end
      end
      ST_WAIT: begin
        if (r_cnt == 4'd1) begin
          w_state_nxt = ST_RESP;
          if (!r_we && !r_err) begin
            w_ram_en  = 1'b1;
            w_rd_load = 1'b1;
          end
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
        end
      end
      ST_RESP: begin
        if (i_rsp_ready) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= ST_IDLE;
      r_req_ready <= 1'b0;
      r_cnt       <= 4'd0;
      r_err       <= 1'b0;
      r_rd_sel    <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_req_ready <= (w_state_nxt == ST_IDLE);
      r_cnt       <= w_cnt_nxt;
      if (w_accept) r_err <= w_err_in;
      if (w_state_nxt == ST_RESP && r_state != ST_RESP) r_rd_sel <= w_rd_load;
      else if (w_state_nxt != ST_RESP)                  r_rd_sel <= 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_accept) begin
      r_we  <= i_req_we;
      r_idx <= i_req_addr[AW+1:2];
    end
  end

  cilantro_dmem_array #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .AW          (AW)
  ) u_array (
    .i_clk   (i_clk),
    .i_en    (w_ram_en),
    .i_we    (w_ram_we),
    .i_be    (i_req_be),
    .i_idx   (w_ram_idx),
    .i_wdata (i_req_wdata),
    .o_rdata (w_ram_q)
  );

  assign o_req_ready = r_req_ready;
  assign o_rsp_valid = (r_state == ST_RESP);
  assign o_rsp_err   = r_err && (r_state == ST_RESP);
  assign o_rsp_rdata = r_rd_sel ? w_ram_q : '0;

endmodule

// File: tb/tb_cilantro_dmem_resp.sv
// Bench for cilantro_dmem_resp: a LATENCY=1 and a LATENCY=4 instance share clock
// and reset; a vector table drives the latency-1 part, hand sequences cover the rest.
module tb_cilantro_dmem_resp;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid [2];
  logic        req_ready [2];
  logic        req_we    [2];
  logic [31:0] req_addr  [2];
  logic [31:0] req_wdata [2];
  logic [3:0]  req_be    [2];
  logic        rsp_valid [2];
  logic        rsp_ready [2];
  logic [31:0] rsp_rdata [2];
  logic        rsp_err   [2];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  cilantro_dmem_resp #(.DEPTH_WORDS(1024), .LATENCY(1)) u_dut1 (
    .i_clk(clk), .i_rst(rst),
    .i_req_valid(req_valid[0]), .o_req_ready(req_ready[0]), .i_req_we(req_we[0]),
    .i_req_addr(req_addr[0]), .i_req_wdata(req_wdata[0]), .i_req_be(req_be[0]),
    .o_rsp_valid(rsp_valid[0]), .i_rsp_ready(rsp_ready[0]),
    .o_rsp_rdata(rsp_rdata[0]), .o_rsp_err(rsp_err[0])
  );

  cilantro_dmem_resp #(.DEPTH_WORDS(1024), .LATENCY(4)) u_dut4 (
    .i_clk(clk), .i_rst(rst),
    .i_req_valid(req_valid[1]), .o_req_ready(req_ready[1]), .i_req_we(req_we[1]),
    .i_req_addr(req_addr[1]), .i_req_wdata(req_wdata[1]), .i_req_be(req_be[1]),
    .o_rsp_valid(rsp_valid[1]), .i_rsp_ready(rsp_ready[1]),
    .o_rsp_rdata(rsp_rdata[1]), .o_rsp_err(rsp_err[1])
  );

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // Full transaction; called just after a rising edge (#1). lat counts edges from
  // acceptance to the first sample where rsp_valid is seen, starting at 1.
  task automatic txn(input int d, input logic we, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic [3:0] be,
                     output logic [31:0] rdata, output logic err, output int lat);
    int k;
    req_valid[d] = 1'b1; req_we[d] = we; req_addr[d] = addr;
    req_wdata[d] = wdata; req_be[d] = be; rsp_ready[d] = 1'b0;
    k = 0;
    while (!req_ready[d] && k < 50) begin
      @(posedge clk); #1; k++;
    end
    if (!req_ready[d]) begin
      n_tests++; n_fail++;
      $display("FAIL txn_ready_timeout: req_ready stuck at 0, expected 1");
    end
    @(posedge clk); #1;
    req_valid[d] = 1'b0;
    lat = 1;
    while (!rsp_valid[d] && lat < 40) begin
      @(posedge clk); #1; lat++;
    end
    rdata = rsp_rdata[d];
    err   = rsp_err[d];
    rsp_ready[d] = 1'b1;
    @(posedge clk); #1;
    rsp_ready[d] = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        tbl [16];
    logic [31:0] rd;
    logic        er;
    int          lat;
    int          n_acc, last_acc, n_rsp, cyc, gap_bad;
    logic        prev_ready, bad_valid;
    logic [31:0] b2b_addr [3];
    logic [31:0] b2b_exp  [3];

    for (int d = 0; d < 2; d++) begin
      req_valid[d] = 1'b0; req_we[d] = 1'b0; req_addr[d] = '0;
      req_wdata[d] = '0; req_be[d] = '0; rsp_ready[d] = 1'b0;
    end

    tbl[0]  = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 32'h0,         1'b0};
    tbl[1]  = '{1'b0, 32'h0000_0010, 32'h0,         4'h0, 32'hDEAD_BEEF, 1'b0};
    tbl[2]  = '{1'b1, 32'h0000_0020, 32'h1122_3344, 4'hF, 32'h0,         1'b0};
    tbl[3]  = '{1'b1, 32'h0000_0020, 32'hAABB_CCDD, 4'h5, 32'h0,         1'b0};
    tbl[4]  = '{1'b0, 32'h0000_0020, 32'h0,         4'hF, 32'h11BB_33DD, 1'b0};
    tbl[5]  = '{1'b1, 32'h0000_0000, 32'h1234_5678, 4'hF, 32'h0,         1'b0};
    tbl[6]  = '{1'b0, 32'h0000_0002, 32'h0,         4'hF, 32'h0,         1'b1};
    tbl[7]  = '{1'b1, 32'h0000_1000, 32'hFFFF_FFFF, 4'hF, 32'h0,         1'b1};
    tbl[8]  = '{1'b0, 32'h0000_0000, 32'h0,         4'h0, 32'h1234_5678, 1'b0};
    tbl[9]  = '{1'b1, 32'h0000_0FFC, 32'hCAFE_F00D, 4'hF, 32'h0,         1'b0};
    tbl[10] = '{1'b0, 32'h0000_0FFC, 32'h0,         4'h0, 32'hCAFE_F00D, 1'b0};
    tbl[11] = '{1'b1, 32'h0000_0FFC, 32'h0,         4'h0, 32'h0,         1'b0};
    tbl[12] = '{1'b0, 32'h0000_0FFC, 32'h0,         4'h0, 32'hCAFE_F00D, 1'b0};
    tbl[13] = '{1'b0, 32'h8000_0010, 32'h0,         4'h0, 32'h0,         1'b1};
    tbl[14] = '{1'b1, 32'h0000_0011, 32'h0BAD_0BAD, 4'hF, 32'h0,         1'b1};
    tbl[15] = '{1'b0, 32'h0000_0010, 32'h0,         4'h0, 32'hDEAD_BEEF, 1'b0};

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("rst_req_ready%0d", d), 32'(req_ready[d]), 32'h0);
      chk($sformatf("rst_rsp_valid%0d", d), 32'(rsp_valid[d]), 32'h0);
      chk($sformatf("rst_rsp_rdata%0d", d), rsp_rdata[d], 32'h0);
      chk($sformatf("rst_rsp_err%0d", d),   32'(rsp_err[d]), 32'h0);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_ready0", 32'(req_ready[0]), 32'h1);
    chk("post_rst_ready1", 32'(req_ready[1]), 32'h1);

    // Vector table on the latency-1 instance
    for (int i = 0; i < 16; i++) begin
      txn(0, tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].be, rd, er, lat);
      chk($sformatf("vec%0d_rdata", i), rd, tbl[i].exp_rdata);
      chk($sformatf("vec%0d_err", i), 32'(er), 32'(tbl[i].exp_err));
      chk($sformatf("vec%0d_lat", i), 32'(lat), 32'd1);
    end

    // Latency 4: cycle-exact rsp_valid, then response held under backpressure
    txn(1, 1'b1, 32'h0000_0030, 32'h5555_AAAA, 4'hF, rd, er, lat);
    chk("l4_store_lat", 32'(lat), 32'd4);
    chk("l4_store_rdata", rd, 32'h0);
    req_valid[1] = 1'b1; req_we[1] = 1'b0; req_addr[1] = 32'h0000_0030;
    chk("l4_ready_before", 32'(req_ready[1]), 32'h1);
    @(posedge clk); #1;
    req_valid[1] = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      chk($sformatf("l4_valid_c%0d", c), 32'(rsp_valid[1]), 32'(c == 4));
      chk($sformatf("l4_ready_c%0d", c), 32'(req_ready[1]), 32'h0);
      if (c < 4) begin
        @(posedge clk); #1;
      end
    end
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      chk($sformatf("l4_hold_valid%0d", c), 32'(rsp_valid[1]), 32'h1);
      chk($sformatf("l4_hold_rdata%0d", c), rsp_rdata[1], 32'h5555_AAAA);
      chk($sformatf("l4_hold_ready%0d", c), 32'(req_ready[1]), 32'h0);
    end
    rsp_ready[1] = 1'b1;
    @(posedge clk); #1;
    rsp_ready[1] = 1'b0;
    chk("l4_done_valid", 32'(rsp_valid[1]), 32'h0);
    chk("l4_done_ready", 32'(req_ready[1]), 32'h1);
    chk("l4_done_rdata", rsp_rdata[1], 32'h0);

    // Reset while in WAIT after a store: response dropped, store kept
    req_valid[1] = 1'b1; req_we[1] = 1'b1; req_addr[1] = 32'h0000_0040;
    req_wdata[1] = 32'h5A5A_5A5A; req_be[1] = 4'hF;
    @(posedge clk); #1;
    req_valid[1] = 1'b0;
    bad_valid = rsp_valid[1];
    @(posedge clk); #1;
    bad_valid |= rsp_valid[1];
    rst = 1'b1;
    repeat (2) begin
      @(posedge clk); #1;
      bad_valid |= rsp_valid[1];
    end
    rst = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      bad_valid |= rsp_valid[1];
    end
    chk("rstwait_no_valid", 32'(bad_valid), 32'h0);
    chk("rstwait_ready", 32'(req_ready[1]), 32'h1);
    txn(1, 1'b0, 32'h0000_0040, 32'h0, 4'h0, rd, er, lat);
    chk("rstwait_load", rd, 32'h5A5A_5A5A);
    chk("rstwait_err", 32'(er), 32'h0);

    // Back-to-back loads, req_valid and rsp_ready held high, latency 1
    b2b_addr[0] = 32'h0000_0010; b2b_exp[0] = 32'hDEAD_BEEF;
    b2b_addr[1] = 32'h0000_0020; b2b_exp[1] = 32'h11BB_33DD;
    b2b_addr[2] = 32'h0000_0000; b2b_exp[2] = 32'h1234_5678;
    n_acc = 0; n_rsp = 0; last_acc = -1; gap_bad = 0;
    req_we[0] = 1'b0; req_addr[0] = b2b_addr[0];
    req_valid[0] = 1'b1; rsp_ready[0] = 1'b1;
    for (cyc = 0; cyc < 12; cyc++) begin
      prev_ready = req_ready[0] && req_valid[0];
      @(posedge clk); #1;
      if (prev_ready) begin
        if (last_acc >= 0 && cyc - last_acc != 2) gap_bad++;
        last_acc = cyc;
        n_acc++;
        if (n_acc < 3) req_addr[0] = b2b_addr[n_acc];
        else req_valid[0] = 1'b0;
      end
      if (rsp_valid[0]) begin
        if (n_rsp < 3) chk($sformatf("b2b_rdata%0d", n_rsp), rsp_rdata[0], b2b_exp[n_rsp]);
        n_rsp++;
      end
    end
    rsp_ready[0] = 1'b0;
    chk("b2b_accepts", 32'(n_acc), 32'd3);
    chk("b2b_responses", 32'(n_rsp), 32'd3);
    chk("b2b_gap_errors", 32'(gap_bad), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
